// File: rtl/train_ctrl_pkg.sv
// Shared definitions for the train controller condition path: condition
// modes, configuration word layout and the power-on condition table.
package train_ctrl_pkg;

  typedef enum logic [1:0] {
    COND_ANY   = 2'd0,
    COND_NONE  = 2'd1,
    COND_TIMER = 2'd2,
    COND_ZERO  = 2'd3
  } cond_mode_e;

  localparam int CFG_MODE_W   = 2;
  localparam int CFG_MASK_LSB = 0;

  // The mode field sits directly above the sensor mask.
  function automatic int cfg_mode_lsb(input int n_sensors);
    return n_sensors;
  endfunction

  // Default mode per table entry; boards with fewer than six sensors get an all-ZERO table.
  function automatic cond_mode_e default_mode(input int idx, input int n_sensors, input int sel_w);
    cond_mode_e mode;
    mode = COND_ZERO;
    if (n_sensors >= 6 && idx < (1 << sel_w) && idx < 16) begin
      case (idx)
        2, 3, 4, 5: mode = COND_TIMER;
        10, 11:     mode = COND_NONE;
        default:    mode = COND_ANY;
      endcase
    end
    return mode;
  endfunction

  // Default sensor mask per table entry (bit i = sensor S(i+1)).
  function automatic logic [31:0] default_mask(input int idx, input int n_sensors, input int sel_w);
    logic [31:0] mask;
    mask = 32'h0;
    if (n_sensors >= 6 && idx < (1 << sel_w) && idx < 16) begin
      case (idx)
        0:       mask = 32'h21;
        1:       mask = 32'h12;
        6, 9:    mask = 32'h04;
        7, 8:    mask = 32'h08;
        10:      mask = 32'h0F;
        11:      mask = 32'h3C;
        12, 14:  mask = 32'h20;
        13, 15:  mask = 32'h01;
        default: mask = 32'h00;
      endcase
    end
    return mask;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One track sensor: two-flop synchroniser followed by a stability counter.
// A change is accepted only after DEBOUNCE_CYC consecutive differing samples.
module sensor_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Count differing samples; flip the stable level on the last one and restart.
  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Synchroniser, counter and stable level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/sensor_condition_sync.sv
// Debounced sensors feed a programmable per-state condition table; the
// selected condition is registered and turned into a rise pulse and a
// req/ack event for the main controller FSM.
module sensor_condition_sync
  import train_ctrl_pkg::*;
#(
  parameter int N_SENSORS    = 6,
  parameter int SEL_W        = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_SENSORS-1:0] SENSORS,
  input  logic                 TIMER,
  input  logic [SEL_W-1:0]     Selector,
  input  logic                 Enable,
  input  logic                 CFG_WE,
  input  logic [SEL_W-1:0]     CFG_ADDR,
  input  logic [N_SENSORS+1:0] CFG_DATA,
  output logic                 COND,
  output logic                 COND_RISE,
  output logic                 EVT_REQ,
  input  logic                 EVT_ACK,
  output logic                 OVERRUN,
  output logic [N_SENSORS-1:0] SENS_STABLE
);

  localparam int DEPTH    = 1 << SEL_W;
  localparam int ENTRY_W  = N_SENSORS + 2;
  localparam int MODE_LSB = cfg_mode_lsb(N_SENSORS);

  logic [N_SENSORS-1:0] stable;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sensor
    sensor_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk     (CLK),
      .rst     (RST),
      .raw_i   (SENSORS[g]),
      .stable_o(stable[g])
    );
  end

  logic [ENTRY_W-1:0] table_q [DEPTH];
  logic [ENTRY_W-1:0] table_d [DEPTH];

  // Table write port; the new entry is only visible to evaluation next cycle.
  always_comb begin
    table_d = table_q;
    if (CFG_WE) begin
      table_d[CFG_ADDR] = CFG_DATA;
    end
  end

  // Table storage, reloaded with the default condition map on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= {default_mode(i, N_SENSORS, SEL_W),
                       N_SENSORS'(default_mask(i, N_SENSORS, SEL_W))};
      end
    end else begin
      table_q <= table_d;
    end
  end

  logic [ENTRY_W-1:0]   sel_entry;
  cond_mode_e           sel_mode;
  logic [N_SENSORS-1:0] hits;
  logic                 eval_cond;

  // Evaluate the entry addressed by the current controller state.
  always_comb begin
    sel_entry = table_q[Selector];
    sel_mode  = cond_mode_e'(sel_entry[MODE_LSB +: CFG_MODE_W]);
    hits      = stable & sel_entry[CFG_MASK_LSB +: N_SENSORS];
    case (sel_mode)
      COND_ANY:   eval_cond = |hits;
      COND_NONE:  eval_cond = ~|hits;
      COND_TIMER: eval_cond = TIMER;
      default:    eval_cond = 1'b0;
    endcase
  end

  logic             cond_q, cond_d;
  logic             cond_prev_q, cond_prev_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_chg_q, sel_chg_d;
  logic             evt_req_q, evt_req_d;
  logic             overrun_q, overrun_d;
  logic             sel_diff;
  logic             rise;

  // Edge detection and event handshake; a state change or disable drops any pending event.
  always_comb begin
    sel_diff    = (Selector != sel_q);
    cond_d      = Enable & eval_cond;
    cond_prev_d = cond_q;
    sel_d       = Selector;
    sel_chg_d   = sel_diff;
    rise        = cond_q & ~cond_prev_q & Enable & ~sel_chg_q;
    evt_req_d   = evt_req_q;
    if (!Enable || sel_diff) begin
      evt_req_d = 1'b0;
    end else if (rise) begin
      evt_req_d = 1'b1;
    end else if (EVT_ACK) begin
      evt_req_d = 1'b0;
    end
    overrun_d = overrun_q | (rise & evt_req_q & ~EVT_ACK);
  end

  // Condition, selector history and handshake registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cond_q      <= 1'b0;
      cond_prev_q <= 1'b0;
      sel_q       <= '0;
      sel_chg_q   <= 1'b0;
      evt_req_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cond_q      <= cond_d;
      cond_prev_q <= cond_prev_d;
      sel_q       <= sel_d;
      sel_chg_q   <= sel_chg_d;
      evt_req_q   <= evt_req_d;
      overrun_q   <= overrun_d;
    end
  end

  assign COND        = cond_q;
  assign COND_RISE   = rise;
  assign EVT_REQ     = evt_req_q;
  assign OVERRUN     = overrun_q;
  assign SENS_STABLE = stable;

endmodule

// File: tb/tb_sensor_condition_sync.sv
// Directed bench for sensor_condition_sync with hand-computed expectations.
module tb_sensor_condition_sync;

  localparam int N = 6;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [N-1:0]  SENSORS;
  logic          TIMER;
  logic [SW-1:0] Selector;
  logic          Enable;
  logic          CFG_WE;
  logic [SW-1:0] CFG_ADDR;
  logic [N+1:0]  CFG_DATA;
  logic          COND;
  logic          COND_RISE;
  logic          EVT_REQ;
  logic          EVT_ACK;
  logic          OVERRUN;
  logic [N-1:0]  SENS_STABLE;

  int   vectors = 0;
  int   miscompares = 0;
  logic seen_cond, seen_rise, seen_s3;

  sensor_condition_sync #(
    .N_SENSORS(N),
    .SEL_W(SW),
    .DEBOUNCE_CYC(4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SENSORS    (SENSORS),
    .TIMER      (TIMER),
    .Selector   (Selector),
    .Enable     (Enable),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_DATA   (CFG_DATA),
    .COND       (COND),
    .COND_RISE  (COND_RISE),
    .EVT_REQ    (EVT_REQ),
    .EVT_ACK    (EVT_ACK),
    .OVERRUN    (OVERRUN),
    .SENS_STABLE(SENS_STABLE)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] sens, input logic tmr,
                               input logic [SW-1:0] sel, input logic en);
    SENSORS  = sens;
    TIMER    = tmr;
    Selector = sel;
    Enable   = en;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Directed sequence; every check happens 1 ns after a rising edge.
  initial begin
    RST = 1'b1; EVT_ACK = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    applyStimulus(6'b000000, 1'b0, 4'd0, 1'b0);
    stepCycles(2);
    checkOutput("rst_cond", 32'(COND), 0);
    checkOutput("rst_rise", 32'(COND_RISE), 0);
    checkOutput("rst_req", 32'(EVT_REQ), 0);
    checkOutput("rst_ovr", 32'(OVERRUN), 0);
    checkOutput("rst_stable", 32'(SENS_STABLE), 0);
    RST = 1'b0;

    // S1 on entry 0: seven-cycle latency, single-cycle rise, held request.
    applyStimulus(6'b000000, 1'b0, 4'd0, 1'b1);
    stepCycles(2);
    checkOutput("s1_idle_cond", 32'(COND), 0);
    applyStimulus(6'b000001, 1'b0, 4'd0, 1'b1);
    stepCycles(6);
    checkOutput("s1_cond_at6", 32'(COND), 0);
    checkOutput("s1_stable_at6", 32'(SENS_STABLE), 32'h01);
    stepCycles(1);
    checkOutput("s1_cond_at7", 32'(COND), 1);
    checkOutput("s1_rise_at7", 32'(COND_RISE), 1);
    checkOutput("s1_req_at7", 32'(EVT_REQ), 0);
    stepCycles(1);
    checkOutput("s1_rise_at8", 32'(COND_RISE), 0);
    checkOutput("s1_req_at8", 32'(EVT_REQ), 1);
    stepCycles(3);
    checkOutput("s1_req_held", 32'(EVT_REQ), 1);
    EVT_ACK = 1'b1;
    stepCycles(1);
    EVT_ACK = 1'b0;
    checkOutput("s1_req_acked", 32'(EVT_REQ), 0);

    // Three-cycle glitch on S3 with entry 6 must be filtered out.
    applyStimulus(6'b000001, 1'b0, 4'd6, 1'b1);
    stepCycles(2);
    checkOutput("glitch_pre_cond", 32'(COND), 0);
    seen_cond = 1'b0; seen_rise = 1'b0; seen_s3 = 1'b0;
    applyStimulus(6'b000101, 1'b0, 4'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      stepCycles(1);
      seen_cond |= COND; seen_rise |= COND_RISE; seen_s3 |= SENS_STABLE[2];
    end
    applyStimulus(6'b000001, 1'b0, 4'd6, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stepCycles(1);
      seen_cond |= COND; seen_rise |= COND_RISE; seen_s3 |= SENS_STABLE[2];
    end
    checkOutput("glitch_cond", 32'(seen_cond), 0);
    checkOutput("glitch_rise", 32'(seen_rise), 0);
    checkOutput("glitch_s3", 32'(seen_s3), 0);
    checkOutput("glitch_stable", 32'(SENS_STABLE), 32'h01);

    // NONE S1..S4 on entry 10: true with all sensors low, falls when S2 rises.
    applyStimulus(6'b000000, 1'b0, 4'd10, 1'b0);
    stepCycles(8);
    checkOutput("none_stable0", 32'(SENS_STABLE), 0);
    checkOutput("none_dis_cond", 32'(COND), 0);
    applyStimulus(6'b000000, 1'b0, 4'd10, 1'b1);
    stepCycles(1);
    checkOutput("none_cond", 32'(COND), 1);
    checkOutput("none_rise", 32'(COND_RISE), 1);
    stepCycles(1);
    checkOutput("none_req", 32'(EVT_REQ), 1);
    EVT_ACK = 1'b1;
    stepCycles(1);
    EVT_ACK = 1'b0;
    checkOutput("none_req_acked", 32'(EVT_REQ), 0);
    applyStimulus(6'b000010, 1'b0, 4'd10, 1'b1);
    stepCycles(6);
    checkOutput("none_s2_at6", 32'(COND), 1);
    stepCycles(1);
    checkOutput("none_s2_at7", 32'(COND), 0);
    checkOutput("none_s2_rise", 32'(COND_RISE), 0);
    checkOutput("none_s2_stable", 32'(SENS_STABLE), 32'h02);

    // TIMER entry: one-cycle latency, ack in the rise cycle loses to the new event.
    applyStimulus(6'b000010, 1'b0, 4'd2, 1'b1);
    stepCycles(2);
    checkOutput("tmr_pre_cond", 32'(COND), 0);
    applyStimulus(6'b000010, 1'b1, 4'd2, 1'b1);
    stepCycles(1);
    checkOutput("tmr_cond", 32'(COND), 1);
    checkOutput("tmr_rise", 32'(COND_RISE), 1);
    EVT_ACK = 1'b1;
    stepCycles(1);
    EVT_ACK = 1'b0;
    checkOutput("tmr_req_wins", 32'(EVT_REQ), 1);
    checkOutput("tmr_no_ovr", 32'(OVERRUN), 0);

    // Second rise while the event is still pending sets the sticky overrun.
    applyStimulus(6'b000010, 1'b0, 4'd2, 1'b1);
    stepCycles(1);
    checkOutput("ovr_cond_low", 32'(COND), 0);
    checkOutput("ovr_req_pend", 32'(EVT_REQ), 1);
    applyStimulus(6'b000010, 1'b1, 4'd2, 1'b1);
    stepCycles(1);
    checkOutput("ovr_rise2", 32'(COND_RISE), 1);
    stepCycles(1);
    checkOutput("ovr_set", 32'(OVERRUN), 1);
    checkOutput("ovr_req", 32'(EVT_REQ), 1);
    applyStimulus(6'b000010, 1'b1, 4'd3, 1'b1);
    stepCycles(1);
    checkOutput("sel3_req_clr", 32'(EVT_REQ), 0);
    checkOutput("sel3_cond", 32'(COND), 1);
    checkOutput("sel3_rise", 32'(COND_RISE), 0);
    applyStimulus(6'b000010, 1'b1, 4'd2, 1'b1);
    stepCycles(3);
    checkOutput("ovr_sticky", 32'(OVERRUN), 1);
    checkOutput("sel2_req", 32'(EVT_REQ), 0);

    // Runtime write of entry 7 to NONE S1 while it is selected.
    applyStimulus(6'b000010, 1'b0, 4'd7, 1'b1);
    stepCycles(2);
    checkOutput("cfg_pre_cond", 32'(COND), 0);
    CFG_WE = 1'b1; CFG_ADDR = 4'd7; CFG_DATA = 8'b01_000001;
    stepCycles(1);
    CFG_WE = 1'b0;
    checkOutput("cfg_write_cyc", 32'(COND), 0);
    stepCycles(1);
    checkOutput("cfg_new_cond", 32'(COND), 1);
    checkOutput("cfg_new_rise", 32'(COND_RISE), 1);

    // Reset with a concurrent table write: reset clears state and restores defaults.
    RST = 1'b1; CFG_WE = 1'b1; CFG_ADDR = 4'd0; CFG_DATA = 8'b11_000000;
    stepCycles(1);
    checkOutput("rst2_cond", 32'(COND), 0);
    checkOutput("rst2_rise", 32'(COND_RISE), 0);
    checkOutput("rst2_req", 32'(EVT_REQ), 0);
    checkOutput("rst2_ovr", 32'(OVERRUN), 0);
    checkOutput("rst2_stable", 32'(SENS_STABLE), 0);
    RST = 1'b0; CFG_WE = 1'b0;
    applyStimulus(6'b100000, 1'b0, 4'd0, 1'b1);
    stepCycles(6);
    checkOutput("rst2_s6_at6", 32'(COND), 0);
    stepCycles(1);
    checkOutput("rst2_s6_at7", 32'(COND), 1);
    checkOutput("rst2_s6_rise", 32'(COND_RISE), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
